// File: rtl/img_proc_pipe_if.sv
// Pixel stream bundle for img_proc_pipe: raw Bayer beats in, processed greyscale/Sobel pixels out.
interface img_proc_pipe_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CW     = 11
);
  logic              iSOF;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic [DATA_W-1:0] oPIX;
  logic              oDVAL;
  logic [CW-1:0]     oX;
  logic [CW-1:0]     oY;

  modport master (
    output iSOF, iMODE, iDATA, iDVAL,
    input  oPIX, oDVAL, oX, oY
  );

  modport slave (
    input  iSOF, iMODE, iDATA, iDVAL,
    output oPIX, oDVAL, oX, oY
  );
endinterface

// File: rtl/img_proc_pipe.sv
// Bayer 2x2 binning to greyscale with optional 3x3 Sobel (X, Y or |Gx|+|Gy|), border gated,
// saturated, fixed two-cycle latency from the completing raw beat to oDVAL.
module img_proc_pipe #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned CW     = 11
) (
  input logic              iCLK,
  input logic              iRST,
  img_proc_pipe_if.slave   bus_io
);

  localparam int unsigned HalfW = IMG_W / 2;
  localparam int unsigned AW    = (HalfW > 1) ? $clog2(HalfW) : 1;
  localparam int unsigned SW    = DATA_W + 3;
  localparam int unsigned RW    = DATA_W + 4;
  localparam logic [DATA_W-1:0] PixMax = '1;

  logic [CW-1:0]     rx_q, rx_d, ry_q, ry_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] pend_q, pend_d;

  logic [DATA_W:0]   rbuf  [HalfW];
  logic [DATA_W-1:0] gbuf0 [HalfW];
  logic [DATA_W-1:0] gbuf1 [HalfW];

  logic              s1_vld_q, s1_vld_d;
  logic [CW-1:0]     s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];

  logic              dval_q, dval_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [CW-1:0]     ox_q, ox_d, oy_q, oy_d;

  logic [CW-1:0]     bx, by;
  logic [AW-1:0]     gidx;
  logic              raw_we, grey_vld;
  logic [DATA_W:0]   pair_sum;
  logic [DATA_W+1:0] gsum;
  logic [DATA_W-1:0] grey;

  // iSOF makes the current beat (0,0) regardless of where the counters were.
  always_comb begin
    bx       = bus_io.iSOF ? '0 : rx_q;
    by       = bus_io.iSOF ? '0 : ry_q;
    gidx     = AW'(bx >> 1);
    raw_we   = bus_io.iDVAL & bx[0] & ~by[0];
    grey_vld = bus_io.iDVAL & bx[0] & by[0];
    pair_sum = {1'b0, pend_q} + {1'b0, bus_io.iDATA};
    gsum     = {1'b0, rbuf[gidx]} + {2'b00, pend_q} + {2'b00, bus_io.iDATA};
    grey     = DATA_W'(gsum >> 2);
  end

  always_comb begin
    rx_d   = rx_q;
    ry_d   = ry_q;
    mode_d = mode_q;
    pend_d = pend_q;
    if (bus_io.iSOF) begin
      rx_d   = '0;
      ry_d   = '0;
      mode_d = bus_io.iMODE;
    end
    if (bus_io.iDVAL) begin
      if (!bx[0]) pend_d = bus_io.iDATA;
      if (bx == CW'(IMG_W - 1)) begin
        rx_d = '0;
        ry_d = (by == CW'(IMG_H - 1)) ? '0 : by + 1'b1;
      end else begin
        rx_d = bx + 1'b1;
        ry_d = by;
      end
    end
  end

  // Stage 1: new window column is {two rows up, one row up, this row} at binned column gx.
  always_comb begin
    s1_vld_d  = grey_vld;
    s1_gx_d   = s1_gx_q;
    s1_gy_d   = s1_gy_q;
    s1_mode_d = s1_mode_q;
    win_d     = win_q;
    if (grey_vld) begin
      s1_gx_d   = bx >> 1;
      s1_gy_d   = by >> 1;
      s1_mode_d = mode_q;
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = gbuf1[gidx];
      win_d[1][2] = gbuf0[gidx];
      win_d[2][2] = grey;
    end
  end

  always_ff @(posedge iCLK) begin
    if (raw_we) rbuf[gidx] <= pair_sum;
    if (grey_vld) begin
      gbuf1[gidx] <= gbuf0[gidx];
      gbuf0[gidx] <= grey;
    end
  end

  logic [SW-1:0] xr, xl, yb, yt, ax, ay;
  logic [RW-1:0] res;
  logic          gate;

  // Stage 2: magnitudes via compare-and-subtract, equivalent to abs of the signed gradient.
  always_comb begin
    xr = SW'(win_q[0][2]) + (SW'(win_q[1][2]) << 1) + SW'(win_q[2][2]);
    xl = SW'(win_q[0][0]) + (SW'(win_q[1][0]) << 1) + SW'(win_q[2][0]);
    yb = SW'(win_q[2][0]) + (SW'(win_q[2][1]) << 1) + SW'(win_q[2][2]);
    yt = SW'(win_q[0][0]) + (SW'(win_q[0][1]) << 1) + SW'(win_q[0][2]);
    ax = (xr >= xl) ? xr - xl : xl - xr;
    ay = (yb >= yt) ? yb - yt : yt - yb;
    unique case (s1_mode_q)
      2'd0:    res = RW'(win_q[2][2]);
      2'd1:    res = RW'(ax);
      2'd2:    res = RW'(ay);
      default: res = RW'(ax) + RW'(ay);
    endcase
    gate = (s1_mode_q == 2'd0) || ((s1_gx_q >= CW'(2)) && (s1_gy_q >= CW'(2)));

    dval_d = s1_vld_q & gate;
    pix_d  = pix_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    if (dval_d) begin
      pix_d = (res > {4'b0000, PixMax}) ? PixMax : res[DATA_W-1:0];
      ox_d  = (s1_mode_q == 2'd0) ? s1_gx_q : s1_gx_q - 1'b1;
      oy_d  = (s1_mode_q == 2'd0) ? s1_gy_q : s1_gy_q - 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      rx_q      <= '0;
      ry_q      <= '0;
      mode_q    <= '0;
      pend_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_gx_q   <= '0;
      s1_gy_q   <= '0;
      s1_mode_q <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
      dval_q    <= 1'b0;
      pix_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
    end else begin
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      s1_vld_q  <= s1_vld_d;
      s1_gx_q   <= s1_gx_d;
      s1_gy_q   <= s1_gy_d;
      s1_mode_q <= s1_mode_d;
      win_q     <= win_d;
      dval_q    <= dval_d;
      pix_q     <= pix_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
    end
  end

  assign bus_io.oPIX  = pix_q;
  assign bus_io.oDVAL = dval_q;
  assign bus_io.oX    = ox_q;
  assign bus_io.oY    = oy_q;

endmodule

// File: tb/tb_img_proc_pipe.sv
// Directed bench for img_proc_pipe on an 8x8 raw frame: grey, Sobel modes, mode latch, reset.
module tb_img_proc_pipe;

  localparam int unsigned DW  = 12;
  localparam int unsigned IW  = 8;
  localparam int unsigned IH  = 8;
  localparam int unsigned CWT = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  img_proc_pipe_if #(.DATA_W(DW), .CW(CWT)) bus ();

  img_proc_pipe #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH),
    .CW     (CWT)
  ) dut (
    .iCLK   (clk),
    .iRST   (rst_n),
    .bus_io (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  logic           d1_v;
  logic [DW-1:0]  d1_pix, hold_pix;
  logic [CWT-1:0] d1_x, d1_y, hold_x, hold_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive a beat, then check the outputs owed by the previous beat.
  task automatic step(input logic sof, input logic dval, input logic [DW-1:0] data,
                      input logic cv, input logic [DW-1:0] cpix,
                      input logic [CWT-1:0] cx, input logic [CWT-1:0] cy);
    bus.iSOF  = sof;
    bus.iDVAL = dval;
    bus.iDATA = data;
    @(posedge clk);
    #1;
    chk("odval", 32'(bus.oDVAL), 32'(d1_v));
    if (bus.oDVAL === 1'b1) pulses++;
    if (d1_v) begin
      hold_pix = d1_pix;
      hold_x   = d1_x;
      hold_y   = d1_y;
    end
    chk("opix", 32'(bus.oPIX), 32'(hold_pix));
    chk("ox", 32'(bus.oX), 32'(hold_x));
    chk("oy", 32'(bus.oY), 32'(hold_y));
    d1_v   = cv;
    d1_pix = cpix;
    d1_x   = cx;
    d1_y   = cy;
    bus.iSOF = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, DW'($urandom), 1'b0, '0, '0, '0);
  endtask

  // Reset beat: anything in flight is discarded and outputs read zero afterwards.
  task automatic reset_step();
    rst_n    = 1'b0;
    d1_v     = 1'b0;
    hold_pix = '0;
    hold_x   = '0;
    hold_y   = '0;
    step(1'b0, 1'($urandom), DW'($urandom), 1'b0, '0, '0, '0);
    rst_n = 1'b1;
  endtask

  // pat 0: R=100 G=200 B=300; pat 1: left half 0, right half hi.
  task automatic frame(input bit use_sof, input logic [1:0] fmode, input int pat,
                       input logic [DW-1:0] hi, input logic [DW-1:0] epix, input bit gaps,
                       input int abort_at, input int mid_at, input logic [1:0] mid_mode,
                       input int exp_pulses);
    pulses = 0;
    bus.iMODE = fmode;
    for (int b = 0; b < int'(IW * IH); b++) begin
      int rx = b % int'(IW);
      int ry = b / int'(IW);
      int gx = rx / 2;
      int gy = ry / 2;
      logic [DW-1:0] data;
      logic cv;
      if (b == mid_at) bus.iMODE = mid_mode;
      if (gaps && $urandom_range(0, 2) == 0) idle();
      if (b == abort_at) begin
        reset_step();
        for (int i = 0; i < 4; i++) idle();
        return;
      end
      if (pat == 0) data = (ry % 2 == 0) ? ((rx % 2 == 0) ? DW'(100) : DW'(200))
                                         : ((rx % 2 == 0) ? DW'(200) : DW'(300));
      else data = (rx < int'(IW / 2)) ? '0 : hi;
      cv = (rx % 2 == 1) && (ry % 2 == 1) && (fmode == 2'd0 || (gx >= 2 && gy >= 2));
      if (fmode == 2'd0) step(use_sof && b == 0, 1'b1, data, cv, epix, CWT'(gx), CWT'(gy));
      else step(use_sof && b == 0, 1'b1, data, cv, epix, CWT'(gx - 1), CWT'(gy - 1));
    end
    idle();
    idle();
    chk("pulses", 32'(pulses), 32'(exp_pulses));
  endtask

  initial begin
    bus.iSOF  = 1'b0;
    bus.iDVAL = 1'b0;
    bus.iDATA = '0;
    bus.iMODE = 2'd0;
    d1_v = 1'b0; d1_pix = '0; d1_x = '0; d1_y = '0;
    hold_pix = '0; hold_x = '0; hold_y = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'($urandom), DW'($urandom), 1'b0, '0, '0, '0);
    rst_n = 1'b1;

    frame(1'b1, 2'd0, 0, '0, DW'(200), 1'b0, -1, -1, 2'd0, 16);
    frame(1'b1, 2'd1, 1, DW'(1000), DW'(4000), 1'b0, -1, -1, 2'd0, 4);
    frame(1'b1, 2'd2, 1, DW'(1000), DW'(0), 1'b0, -1, -1, 2'd0, 4);
    frame(1'b1, 2'd3, 1, DW'(4095), DW'(4095), 1'b0, -1, -1, 2'd0, 4);
    // iMODE moves to 1 mid-frame; latched mode stays grey until the next iSOF.
    frame(1'b1, 2'd0, 0, '0, DW'(200), 1'b0, -1, 20, 2'd1, 16);
    frame(1'b1, 2'd1, 1, DW'(1000), DW'(4000), 1'b0, -1, -1, 2'd0, 4);
    // Reset in row 5 right after the (5,5) beat, whose pulse must be dropped.
    frame(1'b1, 2'd1, 1, DW'(1000), DW'(4000), 1'b0, 46, -1, 2'd0, 0);
    frame(1'b1, 2'd1, 1, DW'(1000), DW'(4000), 1'b0, -1, -1, 2'd0, 4);
    frame(1'b1, 2'd1, 1, DW'(1000), DW'(4000), 1'b1, -1, -1, 2'd0, 4);
    // After reset the counters and latched mode restart without any iSOF.
    reset_step();
    frame(1'b0, 2'd0, 0, '0, DW'(200), 1'b0, -1, -1, 2'd0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
